// File: rtl/fir_coe_reload_ctrl.sv
// fir_coe_reload_ctrl: captures a decimation+coefficient readback packet and reloads it into one FIR channel.
module fir_coe_reload_ctrl #(
  parameter int CH_NUM       = 4,
  parameter int CH_W         = 2,
  parameter int COE_NUM      = 51,
  parameter int COE_WDTH     = 29,
  parameter int COE_NUM_HALF = (COE_NUM + 1) / 2
) (
  input  logic                   cfg_clk,
  input  logic                   cfg_rst_n,
  input  logic                   fir_en,
  input  logic                   byte_swap,
  input  logic [CH_W-1:0]        rb_ch,
  input  logic                   rb_vld,
  input  logic                   rb_last,
  input  logic [31:0]            rb_data,
  output logic                   coe_vld,
  input  logic                   coe_tready,
  output logic                   coe_sop,
  output logic                   coe_last,
  output logic [COE_WDTH-1:0]    coe_din,
  output logic [CH_NUM-1:0]      coe_ch_mask,
  output logic                   cfg_vld,
  output logic [CH_NUM*32-1:0]   coe_fir_dec,
  output logic                   busy,
  output logic                   reload_done,
  output logic                   err_len
);
  localparam int CW = $clog2(COE_NUM_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(COE_NUM_HALF - 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, DRAIN, CHECK, RELOAD, CONFIG} state_t;
  state_t state;
  logic [31:0] w, dec_hold;
  logic [CH_W-1:0] ch_hold;
  logic [CW-1:0] cnt, idx;
  logic [COE_WDTH-1:0] coe_buf [COE_NUM_HALF];
  assign w = byte_swap ? {rb_data[7:0], rb_data[15:8], rb_data[23:16], rb_data[31:24]} : rb_data;
  assign busy = state != IDLE;
  always_ff @(posedge cfg_clk)
    if (state == CAPTURE && rb_vld) coe_buf[cnt] <= w[COE_WDTH-1:0];
  always_ff @(posedge cfg_clk or negedge cfg_rst_n)
    if (!cfg_rst_n) begin
      state       <= IDLE;
      dec_hold    <= '0;
      ch_hold     <= '0;
      cnt         <= '0;
      idx         <= '0;
      coe_vld     <= 1'b0;
      coe_sop     <= 1'b0;
      coe_last    <= 1'b0;
      coe_din     <= '0;
      coe_ch_mask <= '0;
      cfg_vld     <= 1'b0;
      coe_fir_dec <= '0;
      reload_done <= 1'b0;
      err_len     <= 1'b0;
    end else if (!fir_en) begin
      state       <= IDLE;
      dec_hold    <= '0;
      ch_hold     <= '0;
      cnt         <= '0;
      idx         <= '0;
      coe_vld     <= 1'b0;
      coe_sop     <= 1'b0;
      coe_last    <= 1'b0;
      coe_din     <= '0;
      coe_ch_mask <= '0;
      cfg_vld     <= 1'b0;
      coe_fir_dec <= '0;
      reload_done <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      // words arriving while a reload is committed are dropped and flagged
      err_len     <= rb_vld && (state == CHECK || state == RELOAD || state == CONFIG);
      cfg_vld     <= 1'b0;
      reload_done <= 1'b0;
      case (state)
        IDLE: if (rb_vld) begin
          dec_hold <= w;
          ch_hold  <= rb_ch;
          cnt      <= '0;
          if (rb_last) err_len <= 1'b1;
          else state <= CAPTURE;
        end
        CAPTURE: if (rb_vld) begin
          cnt <= cnt + 1'b1;
          if (rb_last) begin
            if (cnt == LAST) state <= CHECK;
            else begin
              err_len <= 1'b1;
              state   <= IDLE;
            end
          end else if (cnt == LAST) state <= DRAIN;
        end
        DRAIN: if (rb_vld && rb_last) begin
          err_len <= 1'b1;
          state   <= IDLE;
        end
        CHECK: if (32'(ch_hold) >= CH_NUM) begin
          err_len <= 1'b1;
          state   <= IDLE;
        end else begin
          idx         <= '0;
          coe_vld     <= 1'b1;
          coe_din     <= coe_buf[0];
          coe_sop     <= 1'b1;
          coe_last    <= LAST == '0;
          coe_ch_mask <= CH_NUM'(1) << ch_hold;
          state       <= RELOAD;
        end
        RELOAD: if (coe_tready) begin
          if (coe_last) begin
            coe_vld     <= 1'b0;
            coe_sop     <= 1'b0;
            coe_last    <= 1'b0;
            coe_din     <= '0;
            cfg_vld     <= 1'b1;
            reload_done <= 1'b1;
            for (int n = 0; n < CH_NUM; n++)
              if (ch_hold == CH_W'(n)) coe_fir_dec[n*32 +: 32] <= dec_hold;
            state       <= CONFIG;
          end else begin
            idx      <= idx + 1'b1;
            coe_din  <= coe_buf[idx + 1'b1];
            coe_sop  <= 1'b0;
            coe_last <= (idx + 1'b1) == LAST;
          end
        end
        CONFIG: begin
          coe_ch_mask <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_coe_reload_ctrl.sv
// tb_fir_coe_reload_ctrl: scoreboard bench with a packet-level reference model for the coefficient reload controller.
module tb_fir_coe_reload_ctrl;
  localparam int CH_NUM = 4, CH_W = 3, COE_WDTH = 29, HALF = 26;
  logic cfg_clk = 0, cfg_rst_n = 0, fir_en = 0, byte_swap = 0;
  logic rb_vld = 0, rb_last = 0, coe_tready = 0;
  logic [CH_W-1:0] rb_ch = '0;
  logic [31:0] rb_data = '0;
  logic coe_vld, coe_sop, coe_last, cfg_vld, busy, reload_done, err_len;
  logic [COE_WDTH-1:0] coe_din;
  logic [CH_NUM-1:0] coe_ch_mask;
  logic [CH_NUM*32-1:0] coe_fir_dec;

  fir_coe_reload_ctrl #(.CH_NUM(CH_NUM), .CH_W(CH_W), .COE_NUM(51), .COE_WDTH(COE_WDTH)) dut (
    .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .fir_en(fir_en), .byte_swap(byte_swap),
    .rb_ch(rb_ch), .rb_vld(rb_vld), .rb_last(rb_last), .rb_data(rb_data),
    .coe_vld(coe_vld), .coe_tready(coe_tready), .coe_sop(coe_sop), .coe_last(coe_last),
    .coe_din(coe_din), .coe_ch_mask(coe_ch_mask), .cfg_vld(cfg_vld), .coe_fir_dec(coe_fir_dec),
    .busy(busy), .reload_done(reload_done), .err_len(err_len));

  always #5 cfg_clk = ~cfg_clk;

  typedef struct packed {logic [CH_NUM-1:0] mask; logic [COE_WDTH-1:0] din; logic sop; logic last;} beat_t;
  typedef struct packed {logic [CH_W-1:0] ch; logic [31:0] dec;} cfg_t;
  beat_t beat_q[$];
  cfg_t cfg_q[$];
  logic [31:0] pkt[$];
  logic [31:0] dec_model [CH_NUM];
  int compared = 0, mismatched = 0, err_seen = 0, err_exp = 0, beats_seen = 0, cfgs_seen = 0;
  int tready_mode = 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cond(logic [31:0] d, logic sw);
    return sw ? {<<8{d}} : d;
  endfunction

  function automatic logic [127:0] dec_flat();
    logic [127:0] r = '0;
    for (int n = 0; n < CH_NUM; n++) r[n*32 +: 32] = dec_model[n];
    return r;
  endfunction

  initial begin
    int p = 0;
    forever begin
      @(posedge cfg_clk); #1;
      if (tready_mode == 0) coe_tready = 1'($urandom_range(0, 1));
      else if (tready_mode == 1) coe_tready = 1'b1;
      else coe_tready = (p % 4 == 0) || (p % 4 == 3);
      p++;
    end
  end

  initial begin
    beat_t prev, cur;
    cfg_t c;
    logic stall_prev = 0;
    forever begin
      @(negedge cfg_clk);
      cur = {coe_ch_mask, coe_din, coe_sop, coe_last};
      if (coe_vld && stall_prev) chk("hold_while_stalled", cur, prev);
      if (coe_vld && coe_tready) begin
        beats_seen++;
        if (beat_q.size() == 0) chk("unexpected_beat", {coe_vld, cur}, '0);
        else chk("beat", cur, beat_q.pop_front());
      end
      stall_prev = coe_vld && !coe_tready;
      prev = cur;
      if (cfg_vld) begin
        cfgs_seen++;
        if (cfg_q.size() == 0) chk("unexpected_cfg_vld", cfg_vld, 1'b0);
        else begin
          c = cfg_q.pop_front();
          dec_model[c.ch[1:0]] = c.dec;
          chk("cfg_dec", coe_fir_dec, dec_flat());
          chk("cfg_reload_done", reload_done, 1'b1);
          chk("cfg_after_last_beat", beat_q.size(), 0);
        end
      end
      if (err_len) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic send_word(logic [31:0] d, logic last, logic [CH_W-1:0] ch);
    rb_data = d; rb_last = last; rb_ch = ch; rb_vld = 1'b1;
    @(posedge cfg_clk); #1;
    rb_vld = 1'b0; rb_last = 1'b0;
  endtask

  task automatic send_packet(logic [CH_W-1:0] ch, logic sw, logic gaps);
    logic [31:0] c;
    if (pkt.size() == HALF + 1 && ch < CH_NUM) begin
      for (int i = 0; i < HALF; i++) begin
        c = cond(pkt[i+1], sw);
        beat_q.push_back('{mask: CH_NUM'(1) << ch, din: c[COE_WDTH-1:0], sop: i == 0, last: i == HALF - 1});
      end
      cfg_q.push_back('{ch: ch, dec: cond(pkt[0], sw)});
    end else err_exp++;
    byte_swap = sw;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge cfg_clk); #1; end
      send_word(pkt[i], i == pkt.size() - 1, ch);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) begin @(posedge cfg_clk); #1; end
    chk("idle_timeout", busy, 1'b0);
    @(posedge cfg_clk); #1;
  endtask

  task automatic mk_pkt(int n);
    pkt = {};
    for (int i = 0; i < n; i++) pkt.push_back($urandom);
  endtask

  initial begin
    int b0, c0;
    for (int n = 0; n < CH_NUM; n++) dec_model[n] = '0;
    fir_en = 1;
    repeat (3) @(posedge cfg_clk);
    #1;
    chk("rst_dec", coe_fir_dec, '0);
    chk("rst_ctl", {coe_vld, coe_sop, coe_last, coe_din, coe_ch_mask, cfg_vld, busy, reload_done, err_len}, '0);
    cfg_rst_n = 1;
    @(posedge cfg_clk); #1;

    // sequential packet: dec 8, coefficients 1..26 to channel 2
    b0 = beats_seen; c0 = cfgs_seen;
    pkt = {32'd8};
    for (int k = 0; k < HALF; k++) pkt.push_back(k + 1);
    send_packet(3'd2, 1'b0, 1'b0);
    chk("lat_check_cycle", coe_vld, 1'b0);
    @(posedge cfg_clk); #1;
    chk("lat_first_vld", coe_vld, 1'b1);
    chk("first_mask", coe_ch_mask, 4'b0100);
    chk("first_din", coe_din, 29'd1);
    wait_idle();
    chk("t1_dec", coe_fir_dec, {32'h0, 32'h8, 64'h0});
    chk("t1_beats", beats_seen - b0, HALF);
    chk("t1_cfgs", cfgs_seen - c0, 1);

    // byte-swapped packet to channel 1
    pkt = {32'h1122_3344, 32'h1122_3344};
    for (int k = 1; k < HALF; k++) pkt.push_back(k + 1);
    send_packet(3'd1, 1'b1, 1'b0);
    @(posedge cfg_clk); #1;
    chk("t2_first_din", coe_din, 29'h0433_2211);
    wait_idle();
    chk("t2_dec", coe_fir_dec[63:32], 32'h4433_2211);

    // short and long packets
    b0 = beats_seen; c0 = cfgs_seen;
    mk_pkt(20); send_packet(3'd0, 1'b0, 1'b0); wait_idle();
    chk("t3_short_err", err_seen, err_exp);
    mk_pkt(30); send_packet(3'd0, 1'b0, 1'b0); wait_idle();
    chk("t3_long_err", err_seen, err_exp);
    chk("t3_no_beats", beats_seen - b0, 0);
    chk("t3_no_cfg", cfgs_seen - c0, 0);

    // back-pressure pattern 1-0-0-1
    tready_mode = 2; b0 = beats_seen;
    mk_pkt(HALF + 1); send_packet(3'd3, 1'b0, 1'b0); wait_idle();
    chk("t4_beats", beats_seen - b0, HALF);
    tready_mode = 1;

    // abort mid-reload
    b0 = beats_seen; c0 = cfgs_seen;
    mk_pkt(HALF + 1); send_packet(3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && beats_seen < b0 + 10; i++) begin @(posedge cfg_clk); #1; end
    chk("t5_reached_beat10", beats_seen - b0 >= 10, 1'b1);
    fir_en = 0;
    @(posedge cfg_clk); #1;
    chk("t5_vld_drop", {coe_vld, cfg_vld, coe_ch_mask, busy}, '0);
    chk("t5_dec_clear", coe_fir_dec, '0);
    beat_q.delete(); cfg_q.delete();
    for (int n = 0; n < CH_NUM; n++) dec_model[n] = '0;
    repeat (3) @(posedge cfg_clk);
    #1;
    fir_en = 1;
    chk("t5_no_cfg", cfgs_seen - c0, 0);
    mk_pkt(HALF + 1); send_packet(3'd1, 1'b0, 1'b0); wait_idle();
    chk("t5_fresh_cfg", cfgs_seen - c0, 1);

    // bad channel, then a word injected during reload
    c0 = cfgs_seen;
    mk_pkt(HALF + 1); send_packet(3'd5, 1'b0, 1'b0); wait_idle();
    chk("t6_badch_err", err_seen, err_exp);
    mk_pkt(HALF + 1); send_packet(3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !coe_vld; i++) begin @(posedge cfg_clk); #1; end
    chk("t6_in_reload", coe_vld, 1'b1);
    err_exp++;
    send_word($urandom, 1'b0, 3'd0);
    wait_idle();
    chk("t6_inject_err", err_seen, err_exp);
    chk("t6_cfg", cfgs_seen - c0, 1);

    // randomized packets
    tready_mode = 0;
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 3);
      logic [CH_W-1:0] ch = CH_W'($urandom_range(0, CH_NUM - 1));
      if (kind == 1) mk_pkt($urandom_range(1, HALF));
      else if (kind == 2) mk_pkt($urandom_range(HALF + 2, 40));
      else mk_pkt(HALF + 1);
      if (kind == 3) ch = CH_W'($urandom_range(CH_NUM, 7));
      send_packet(ch, 1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
    end
    repeat (2) @(posedge cfg_clk);
    #1;
    chk("rand_err_count", err_seen, err_exp);
    chk("rand_beat_q_empty", beat_q.size(), 0);
    chk("rand_cfg_q_empty", cfg_q.size(), 0);
    chk("rand_final_dec", coe_fir_dec, dec_flat());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
